// File: rtl/cache_flush.sv
// Invalidation engine for the cache valid-bit store: clears one (way, index) on
// request, or walks every line for a full flush, stalling on clr_ready.
module cache_flush #(
    parameter int WAYS       = 4,
    parameter int TOTAL_SIZE = 16,
    localparam int SETS      = TOTAL_SIZE / WAYS,
    localparam int WW        = $clog2(WAYS),
    localparam int IW        = $clog2(SETS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inv_req,
    input  logic [WW-1:0] inv_way,
    input  logic [IW-1:0] inv_index,
    output logic          inv_ready,
    input  logic          flush_req,
    output logic          flush_busy,
    output logic          flush_done,
    output logic          clr_en,
    output logic [WW-1:0] clr_way,
    output logic [IW-1:0] clr_index,
    input  logic          clr_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INV   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [WW-1:0] way_cnt;
    logic [IW-1:0] idx_cnt;
    logic [WW-1:0] inv_way_q;
    logic [IW-1:0] inv_index_q;

    // Clear port handshake: a clear is transferred on any cycle where
    // clr_en && clr_ready; clr_en and its address hold steady until then.
    // inv_req/inv_ready follow the same rule on the request side.
    assign inv_ready  = (state == IDLE) && !flush_req;
    assign clr_en     = (state == INV) || (state == FLUSH);
    assign flush_busy = (state == FLUSH) || (state == DONE);
    assign flush_done = (state == DONE);

    // Address is a decode of registered state only, so no input reaches clr_* directly.
    assign clr_way   = (state == FLUSH) ? way_cnt :
                       (state == INV)   ? inv_way_q : '0;
    assign clr_index = (state == FLUSH) ? idx_cnt :
                       (state == INV)   ? inv_index_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            way_cnt     <= '0;
            idx_cnt     <= '0;
            inv_way_q   <= '0;
            inv_index_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state <= FLUSH;
                    end else if (inv_req && inv_ready) begin
                        state       <= INV;
                        inv_way_q   <= inv_way;
                        inv_index_q <= inv_index;
                    end
                end
                INV: begin
                    if (clr_ready) state <= IDLE;
                end
                FLUSH: begin
                    // Index is the inner loop; the final accept leaves both counters at 0.
                    if (clr_ready) begin
                        if (idx_cnt == IW'(SETS - 1)) begin
                            idx_cnt <= '0;
                            if (way_cnt == WW'(WAYS - 1)) begin
                                way_cnt <= '0;
                                state   <= DONE;
                            end else begin
                                way_cnt <= way_cnt + WW'(1);
                            end
                        end else begin
                            idx_cnt <= idx_cnt + IW'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_flush.sv
// Bench for cache_flush: directed scenarios plus random traffic, all checked per
// cycle against a queue-based model of which lines remain to be cleared.
module tb_cache_flush;

    localparam int WAYS       = 4;
    localparam int TOTAL_SIZE = 16;
    localparam int SETS       = TOTAL_SIZE / WAYS;
    localparam int WW         = $clog2(WAYS);
    localparam int IW         = $clog2(SETS);
    localparam int W          = WW + IW;
    localparam int LINES      = WAYS * SETS;

    localparam int M_IDLE  = 0;
    localparam int M_INV   = 1;
    localparam int M_FLUSH = 2;
    localparam int M_DONE  = 3;

    logic          clk;
    logic          rst_n;
    logic          inv_req;
    logic [WW-1:0] inv_way;
    logic [IW-1:0] inv_index;
    logic          inv_ready;
    logic          flush_req;
    logic          flush_busy;
    logic          flush_done;
    logic          clr_en;
    logic [WW-1:0] clr_way;
    logic [IW-1:0] clr_index;
    logic          clr_ready;

    int total = 0;
    int bad   = 0;

    // model state
    int           mode = M_IDLE;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] inv_addr;

    cache_flush #(.WAYS(WAYS), .TOTAL_SIZE(TOTAL_SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inv_req    (inv_req),
        .inv_way    (inv_way),
        .inv_index  (inv_index),
        .inv_ready  (inv_ready),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .clr_en     (clr_en),
        .clr_way    (clr_way),
        .clr_index  (clr_index),
        .clr_ready  (clr_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] exp_addr;
        exp_addr = '0;
        if (mode == M_FLUSH)    exp_addr = exp_q[0];
        else if (mode == M_INV) exp_addr = inv_addr;
        check("clr_en",     32'(clr_en),               32'(mode == M_INV || mode == M_FLUSH));
        check("clr_addr",   32'({clr_way, clr_index}), 32'(exp_addr));
        check("flush_busy", 32'(flush_busy),           32'(mode == M_FLUSH || mode == M_DONE));
        check("flush_done", 32'(flush_done),           32'(mode == M_DONE));
        check("inv_ready",  32'(inv_ready),            32'(mode == M_IDLE && !flush_req));
    endtask

    task automatic model_update();
        logic [W-1:0] a;
        case (mode)
            M_IDLE: begin
                if (flush_req) begin
                    mode = M_FLUSH;
                    for (int n = 0; n < LINES; n++) begin
                        a = {WW'(n / SETS), IW'(n % SETS)};
                        exp_q.push_back(a);
                    end
                end else if (inv_req) begin
                    mode     = M_INV;
                    inv_addr = {inv_way, inv_index};
                end
            end
            M_INV:   if (clr_ready) mode = M_IDLE;
            M_FLUSH: begin
                if (clr_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) mode = M_DONE;
                end
            end
            default: mode = M_IDLE;
        endcase
    endtask

    // driver: one clock cycle of inputs, checked half a cycle before the edge
    task automatic step(input logic f, input logic i, input logic [WW-1:0] w,
                        input logic [IW-1:0] x, input logic r);
        @(negedge clk);
        flush_req = f;
        inv_req   = i;
        inv_way   = w;
        inv_index = x;
        clr_ready = r;
        #1;
        check_outputs();
        model_update();
    endtask

    // asynchronous reset in the middle of a cycle
    task automatic do_reset();
        #1;
        rst_n     = 1'b0;
        flush_req = 1'b0;
        inv_req   = 1'b0;
        clr_ready = 1'b0;
        #1;
        check("rst_clr_en",     32'(clr_en),               32'(0));
        check("rst_flush_busy", 32'(flush_busy),           32'(0));
        check("rst_flush_done", 32'(flush_done),           32'(0));
        check("rst_clr_addr",   32'({clr_way, clr_index}), 32'(0));
        mode = M_IDLE;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush_req = 1'b0;
        inv_req   = 1'b0;
        inv_way   = '0;
        inv_index = '0;
        clr_ready = 1'b0;
        #3;
        check("reset_clr_en",     32'(clr_en),               32'(0));
        check("reset_flush_busy", 32'(flush_busy),           32'(0));
        check("reset_flush_done", 32'(flush_done),           32'(0));
        check("reset_clr_addr",   32'({clr_way, clr_index}), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // one-cycle flush pulse, store always ready: done exactly at cycle LINES+1
        step(1'b1, 1'b0, '0, '0, 1'b1);
        for (int k = 1; k <= LINES + 2; k++) begin
            step(1'b0, 1'b0, '0, '0, 1'b1);
            check("lat_done", 32'(flush_done), 32'(k == LINES + 1));
            check("lat_busy", 32'(flush_busy), 32'(k >= 1 && k <= LINES + 1));
        end

        // store ready only every other cycle
        step(1'b1, 1'b0, '0, '0, 1'b0);
        for (int k = 1; k <= 2 * LINES + 3; k++)
            step(1'b0, 1'b0, '0, '0, 1'((k % 2) == 0));

        // single-line invalidate (2,1), immediate accept, then one stalled 3 cycles
        step(1'b0, 1'b1, WW'(2), IW'(1), 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b1, WW'(3), IW'(2), 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b0, 1'b0, '0, '0, 1'b1);

        // flush and invalidate together: flush wins, held invalidate follows
        step(1'b1, 1'b1, WW'(1), IW'(3), 1'b1);
        for (int k = 0; k < LINES + 5; k++) step(1'b0, 1'b1, WW'(1), IW'(3), 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);

        // reset after five accepts, then a fresh flush from (0,0)
        step(1'b1, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, '0, '0, 1'b1);
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < LINES + 3; k++) step(1'b0, 1'b0, '0, '0, 1'b1);

        // flush_req held high: back-to-back flushes
        for (int k = 0; k < 3 * (LINES + 2) + 2; k++) step(1'b1, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < LINES + 2; k++) step(1'b0, 1'b0, '0, '0, 1'b1);

        // random traffic
        for (int k = 0; k < 4000; k++) begin
            step(1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 2) == 0),
                 WW'($urandom_range(0, WAYS - 1)),
                 IW'($urandom_range(0, SETS - 1)),
                 1'($urandom_range(0, 9) < 7));
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
